// File: rtl/adder_responder.sv
// Flow-controlled adder responder: operand pairs are summed on acceptance and the
// {carry, sum} results are returned in order through a small result FIFO.
module adder_responder #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    input  logic             clear,
    output logic [CNT_W-1:0] txn_count,
    output logic [CNT_W-1:0] carry_count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH:0]   mem_reg [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic [CNT_W-1:0] txn_count_reg;
    logic [CNT_W-1:0] carry_count_reg;

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [WIDTH:0]   sum_next;
    logic [WIDTH:0]   head;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign empty = (wr_ptr_reg == rd_ptr_reg);

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && !full;
    assign pop       = out_ready && !empty;

    assign sum_next  = {1'b0, in_a} + {1'b0, in_b};
    assign head      = mem_reg[rd_ptr_reg[AW-1:0]];
    assign out_sum   = head[WIDTH-1:0];
    assign out_carry = head[WIDTH];

    // Storage is reset so the head reads as zero straight out of reset.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    mem_reg[gi] <= '0;
                end else if (push && (wr_ptr_reg[AW-1:0] == AW'(gi))) begin
                    mem_reg[gi] <= sum_next;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txn_count_reg   <= '0;
            carry_count_reg <= '0;
        end else if (clear) begin
            txn_count_reg   <= '0;
            carry_count_reg <= '0;
        end else if (pop) begin
            if (txn_count_reg != CNT_MAX) txn_count_reg <= txn_count_reg + 1'b1;
            if (out_carry && (carry_count_reg != CNT_MAX))
                carry_count_reg <= carry_count_reg + 1'b1;
        end
    end

    assign txn_count   = txn_count_reg;
    assign carry_count = carry_count_reg;
endmodule

// File: tb/tb_adder_responder.sv
// Scoreboard bench for adder_responder: drivers queue expected results, a monitor
// compares each presented result and tracks the statistics counters.
module tb_adder_responder;
    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_sum;
    logic             out_carry;
    logic             clear = 1'b0;
    logic [CNT_W-1:0] txn_count;
    logic [CNT_W-1:0] carry_count;

    int checks = 0;
    int errors = 0;
    int exp_q[$];          // expected a+b as a plain integer
    int m_txn = 0;
    int m_carry = 0;
    bit stim_done = 0;

    adder_responder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_carry(out_carry),
        .clear(clear), .txn_count(txn_count), .carry_count(carry_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Called at posedge+1; holds the pair until accepted, then returns at posedge+1.
    task automatic send(input int a, input int b, output int waited);
        waited = 0;
        in_valid = 1'b1;
        in_a = WIDTH'(a);
        in_b = WIDTH'(b);
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 60) begin
                checks++; errors++;
                $display("FAIL send_timeout: in_ready stuck 0 for pair (%0d,%0d)", a, b);
                break;
            end
        end
        if (in_ready) exp_q.push_back(a + b);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_done", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    // Monitor: samples at negedge+2, compares head, predicts the counters for the next edge.
    initial begin
        int e;
        bit popped;
        bit pcarry;
        forever begin
            @(negedge clk); #2;
            if (!rst_n) begin
                m_txn = 0;
                m_carry = 0;
                continue;
            end
            check("txn_count", int'(txn_count), m_txn);
            check("carry_count", int'(carry_count), m_carry);
            popped = 0;
            pcarry = 0;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL spurious_out: sum %0d carry %0d with empty scoreboard",
                             out_sum, out_carry);
                end else begin
                    e = exp_q[0];
                    check("out_sum", int'(out_sum), e % 16);
                    check("out_carry", int'(out_carry), (e >= 16) ? 1 : 0);
                    if (out_ready) begin
                        $display("txn: sum=%0d carry=%0d", out_sum, out_carry);
                        popped = 1;
                        pcarry = (e >= 16);
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (clear) begin
                m_txn = 0;
                m_carry = 0;
            end else if (popped) begin
                if (m_txn < 65535) m_txn++;
                if (pcarry && m_carry < 65535) m_carry++;
            end
        end
    end

    initial begin
        int w;
        int a, b;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_sum", int'(out_sum), 0);
        check("rst_out_carry", int'(out_carry), 0);
        check("rst_txn", int'(txn_count), 0);
        check("rst_carry_cnt", int'(carry_count), 0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: zero pair, latency one cycle
        out_ready = 1'b1;
        send(0, 0, w);
        check("t1_latency_valid", int'(out_valid), 1);
        drain();
        check("t1_txn", int'(txn_count), 1);

        // 2: carry and no-carry
        send(15, 15, w);
        drain();
        check("t2_carry_cnt_a", int'(carry_count), 1);
        send(7, 7, w);
        drain();
        check("t2_carry_cnt_b", int'(carry_count), 1);

        // 3: backpressure fills the FIFO, fifth pair held until a pop
        out_ready = 1'b0;
        send(1, 2, w); send(3, 4, w); send(5, 6, w); send(7, 8, w);
        check("t3_full_ready", int'(in_ready), 0);
        fork
            send(9, 1, w);
            begin
                repeat (3) @(negedge clk);
                check("t3_held_ready", int'(in_ready), 0);
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        check("t3_held_cycles", (w >= 3) ? 1 : 0, 1);
        drain();

        // 4: streaming odd a / even b
        pulse_clear();
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            a = int'($urandom_range(7, 0)) * 2 + 1;
            b = int'($urandom_range(7, 0)) * 2;
            if (i > 0) check("t4_stream_valid", int'(out_valid), 1);
            send(a, b, w);
            check("t4_no_stall", w, 0);
        end
        drain();
        check("t4_txn", int'(txn_count), 20);

        // 5: simultaneous push/pop at occupancy 2, then clear alongside a pop
        out_ready = 1'b0;
        send(2, 2, w); send(4, 4, w);
        out_ready = 1'b1;
        send(6, 6, w);
        out_ready = 1'b0;
        send(8, 8, w); send(9, 9, w);
        check("t5_full_after", int'(in_ready), 0);
        out_ready = 1'b1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        out_ready = 1'b0;
        check("t5_clear_txn", int'(txn_count), 0);
        check("t5_clear_carry", int'(carry_count), 0);
        drain();

        // Randomized mix with random backpressure
        stim_done = 0;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    send(int'($urandom_range(15, 0)), int'($urandom_range(15, 0)), w);
                    if ($urandom_range(3, 0) == 0) begin
                        @(posedge clk); #1;
                    end
                end
                stim_done = 1;
            end
            begin
                while (!stim_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(2, 0) != 0);
                end
            end
        join
        drain();

        // 6: asynchronous reset with 3 entries queued
        out_ready = 1'b0;
        send(1, 1, w); send(2, 2, w); send(3, 3, w);
        check("t6_pre_txn_nonzero", (txn_count != 0) ? 1 : 0, 1);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("t6_async_valid", int'(out_valid), 0);
        check("t6_async_ready", int'(in_ready), 1);
        check("t6_async_txn", int'(txn_count), 0);
        check("t6_async_carry", int'(carry_count), 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(2, 3, w);
        check("t6_sum_after_reset", int'(out_sum), 5);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/adder_responder.md
Name: adder_responder

Overview:
Registered, flow-controlled responder for the adder operand interface. It accepts operand pairs (a, b) from an initiator over a valid/ready handshake and computes the WIDTH-bit sum plus carry-out. Results are queued in an in-order result FIFO and returned over a second valid/ready handshake. It also keeps transaction and carry-out statistics, and is the synthesizable far end for the adder stimulus BFMs.

Parameters:
WIDTH, 4, operand and sum width in bits (>=1)
DEPTH, 4, result FIFO entries; power of two, >=2
CNT_W, 16, width of the statistics counters

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  responder can accept an operand pair
in_a  input  WIDTH  operand a
in_b  input  WIDTH  operand b
out_valid  output  1  result at FIFO head valid
out_ready  input  1  consumer accepts result
out_sum  output  WIDTH  (a+b) mod 2^WIDTH
out_carry  output  1  carry-out of a+b
clear  input  1  synchronous clear of statistics counters
txn_count  output  CNT_W  results delivered (output handshakes)
carry_count  output  CNT_W  delivered results with out_carry=1

Behaviour:
- Reset (rst_n=0, asynchronous): FIFO empty, pointers=0, out_valid=0, out_sum=0, out_carry=0, in_ready=1, txn_count=0, carry_count=0. A reset mid-operation discards all queued results immediately.
- Accept: push when in_valid && in_ready at a rising edge. The entry stored is {carry, sum} = in_a + in_b, computed at WIDTH+1 bits with zero extension.
- in_ready = !full. It is a function of registered occupancy only, never of out_ready. A full FIFO therefore refuses a push even if a pop occurs in the same cycle.
- Deliver: pop when out_valid && out_ready. out_valid = !empty. out_sum and out_carry always show the head entry and hold stable while out_valid && !out_ready.
- Latency: a pair accepted at edge N into an empty FIFO gives out_valid=1 with its result right after edge N, i.e. in cycle N+1. Throughput is one result per cycle sustained.
- Ordering: strict FIFO. Results leave in acceptance order.
- Occupancy: pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH. full when the low bits are equal and the MSBs differ; empty when the pointers are equal.
- Simultaneous push and pop (not full, not empty): occupancy is unchanged and both pointers advance.
- Push into an empty FIFO with out_ready=1: the entry is not bypassed. It appears the next cycle and can be popped then.
- Counters:
  - txn_count increments on each pop.
  - carry_count increments on a pop whose head out_carry=1.
  - Both saturate at 2^CNT_W-1.
  - clear=1 zeroes both at the next edge and has priority over a same-cycle increment.
- Values on out_sum/out_carry while out_valid=0 are don't-care for checking, but they are 0 after reset.
- No X propagation: in_a/in_b are sampled only on an accepted push.

Test Plan:
1. Reset, then in_a=0, in_b=0 pushed with out_ready=1 -> out_valid one cycle later, out_sum=0, out_carry=0; txn_count=1 after the pop.
2. in_a=15, in_b=15 (WIDTH=4) -> out_sum=14, out_carry=1, carry_count=1. Then in_a=7, in_b=7 -> out_sum=14, out_carry=0, carry_count stays 1.
3. Backpressure: out_ready=0, offer pairs (1,2), (3,4), (5,6), (7,8), (9,1).
   - in_ready drops after the 4th accept and the 5th pair is held.
   - Then out_ready=1 -> results 3, 7, 11, 15 emerge in order, and (9,1) is accepted after the first pop and delivers sum=10, carry=0.
4. Streaming: 20 back-to-back pushes of odd a, even b with out_ready=1 -> one result per cycle, each out_sum == (a+b) mod 16, occupancy never exceeds 1, txn_count=20.
5. Simultaneous push and pop at occupancy 2 -> occupancy stays 2, ordering preserved. clear pulsed in the same cycle as a pop -> both counters read 0 afterwards.
6. With 3 entries queued, drive rst_n low mid-cycle -> out_valid=0 and in_ready=1 without waiting for a clock edge, counters 0. After release the first new pair (2,3) returns sum=5.
